stim_sweep_gen: RTL and testbench
=================================

// Module: stim_sweep_gen
// PURPOSE
// - Synthesizable upstream stimulus stage for small combinational DUTs (e.g. the and_gate family).
// - Sweeps every IN_W-bit input vector in ascending order from 0 to 2^IN_W-1.
// - Waits SETTLE cycles per vector, then samples the DUT response and folds it into a MISR signature.
// - Lets a bench or on-chip self-test check a whole truth table with one signature compare.
// PARAMETERS
// IN_W    5        width of DUT input vector (1..16)
// OUT_W   6        width of DUT response (1..SIG_W)
// SETTLE  1        idle cycles between drive and sample (0..255)
// SIG_W   16       MISR signature width
// POLY    16'h1021 MISR feedback polynomial (SIG_W bits)
// PORTS
// clk         in   1        rising-edge clock
// rst         in   1        reset; the clock is single and the reset is asynchronous and active-high
// start       in   1        one-cycle request to begin a sweep
// resp        in   OUT_W    DUT output, combinationally driven from stim
// stim        out  IN_W     vector presented to DUT
// stim_valid  out  1        stim is stable (DRIVE/WAIT/SAMPLE)
// resp_sample out  1        one-cycle pulse: resp captured this cycle
// busy        out  1        sweep in progress
// done        out  1        level, sweep complete; cleared by next start or rst
// vec_count   out  IN_W+1   vectors sampled so far (reaches 2^IN_W)
// signature   out  SIG_W    running MISR value
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; stim, vec_count, signature=0; all 1-bit outputs=0.
// - FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
// - IDLE/DONE + start:
//   - Clear stim, vec_count, signature and done.
//   - Go to DRIVE next cycle.
// - DRIVE (1 cycle):
//   - stim_valid=1; load settle counter with SETTLE.
//   - Go to WAIT if SETTLE>0, else SAMPLE.
// - WAIT: hold stim; decrement counter; go to SAMPLE when the counter reaches 1.
// - SAMPLE (1 cycle):
//   - resp_sample=1; vec_count+=1.
//   - signature <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended resp.
//   - If stim == all-ones: go to DONE; else stim+=1 and go to DRIVE.
// - stim never wraps:
//   - In DONE, stim holds 2^IN_W-1; stim_valid=0; done=1; busy=0.
// - busy = 1 in DRIVE/WAIT/SAMPLE.
// - start while busy: ignored; no effect on sequence or signature.
// - Timing:
//   - Per-vector cost is SETTLE+2 cycles.
//   - done rises (SETTLE+2)*2^IN_W cycles after the edge that samples start.
// - Width rules:
//   - vec_count is IN_W+1 bits so it reaches 2^IN_W without overflow.
//   - resp is zero-extended to SIG_W.
// - rst asserted mid-sweep aborts the sweep and returns all outputs to their reset values.
// - After rst, the next start restarts the sweep from vector 0.
// TESTING
// 1. Reset: assert rst with no clock edge -> all outputs 0 immediately; state IDLE.
// 2. Loopback (IN_W=2, OUT_W=2, SETTLE=1, resp=stim):
//    - stim sequence 0,1,2,3; exactly 4 resp_sample pulses, each 3 cycles apart.
//    - done 12 cycles after start; vec_count=4; signature=16'h0003.
// 3. Full sweep (IN_W=5, SETTLE=0, resp=&stim):
//    - 32 vectors; done after 64 cycles; vec_count=32.
//    - signature equals the bench's software MISR model.
// 4. start pulsed while busy at vector 2 -> sequence, timing and signature identical to test 2.
// 5. rst pulsed during WAIT of vector 2 -> immediate zeros; a new start sweeps from 0 and ends with signature=16'h0003.
// 6. From DONE, pulse start:
//    - done drops on the next cycle; signature and vec_count clear.
//    - The second sweep reproduces the first result exactly.

Source files
------------

// File: rtl/stim_sweep_gen_if.sv
// ---------------------------------------------------------------------------
// stim_sweep_gen_if
// Bundles the signals between the sweep generator and the rest of the
// system. The generator drives the stimulus vector, the status and the
// running signature. The system drives start and returns the DUT response.
//
// Signals
//   start        system -> gen   one-cycle request to begin a sweep
//   resp         system -> gen   DUT response, combinational from stim
//   stim         gen -> system   vector presented to the DUT
//   stim_valid   gen -> system   stim is stable
//   resp_sample  gen -> system   resp is captured this cycle
//   busy         gen -> system   sweep in progress
//   done         gen -> system   sweep complete (level)
//   vec_count    gen -> system   vectors sampled so far
//   signature    gen -> system   running MISR value
//
// Modports
//   master  generator side
//   slave   system / bench side
// ---------------------------------------------------------------------------
interface stim_sweep_gen_if #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 6,
    parameter int SIG_W = 16
);
    logic             start;
    logic [OUT_W-1:0] resp;
    logic [IN_W-1:0]  stim;
    logic             stim_valid;
    logic             resp_sample;
    logic             busy;
    logic             done;
    logic [IN_W:0]    vec_count;
    logic [SIG_W-1:0] signature;

    modport master (
        input  start, resp,
        output stim, stim_valid, resp_sample, busy, done, vec_count, signature
    );

    modport slave (
        output start, resp,
        input  stim, stim_valid, resp_sample, busy, done, vec_count, signature
    );
endinterface

// File: rtl/stim_sweep_gen.sv
// ---------------------------------------------------------------------------
// stim_sweep_gen
// Stimulus generator for small combinational DUTs. After start it presents
// every IN_W-bit vector from 0 up to all-ones. Each vector is held for
// SETTLE idle cycles, then the DUT response is folded into a MISR
// signature. A whole truth table is therefore verified by one compare of
// the final signature.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   stim_sweep_gen_if.master
//           start, resp                           inputs
//           stim, stim_valid, resp_sample, busy,
//           done, vec_count, signature            registered outputs
//
// Per-vector cost is DRIVE (1) + WAIT (SETTLE) + SAMPLE (1) cycles.
// ---------------------------------------------------------------------------
module stim_sweep_gen #(
    parameter int               IN_W   = 5,
    parameter int               OUT_W  = 6,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(16'h1021)
) (
    input  logic               clk,
    input  logic               rst,
    stim_sweep_gen_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state_q,       state_d;
    logic [IN_W-1:0]  stim_q,        stim_d;
    logic [IN_W:0]    vec_count_q,   vec_count_d;
    logic [SIG_W-1:0] signature_q,   signature_d;
    logic [7:0]       settle_cnt_q,  settle_cnt_d;
    logic             stim_valid_q,  stim_valid_d;
    logic             resp_sample_q, resp_sample_d;
    logic             busy_q,        busy_d;
    logic             done_q,        done_d;

    // One MISR step: shift left, apply feedback when the MSB falls out,
    // then fold in the zero-extended response.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] sig,
        input logic [OUT_W-1:0] r
    );
        logic [SIG_W-1:0] fb;
        fb = sig[SIG_W-1] ? POLY : '0;
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(r);
    endfunction

    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        vec_count_d  = vec_count_q;
        signature_d  = signature_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    stim_d      = '0;
                    vec_count_d = '0;
                    signature_d = '0;
                    state_d     = S_DRIVE;
                end
            end
            S_DRIVE: begin
                settle_cnt_d = 8'(SETTLE);
                state_d      = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
            end
            S_WAIT: begin
                // Counter starts at SETTLE, so WAIT lasts exactly SETTLE cycles.
                settle_cnt_d = settle_cnt_q - 8'd1;
                if (settle_cnt_q <= 8'd1) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                vec_count_d = vec_count_q + 1'b1;
                signature_d = misr_step(signature_q, bus.resp);
                // Stop on the last vector instead of wrapping back to 0.
                if (stim_q == '1) begin
                    state_d = S_DONE;
                end else begin
                    stim_d  = stim_q + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered: decode them from the next state.
        busy_d        = (state_d == S_DRIVE) || (state_d == S_WAIT) ||
                        (state_d == S_SAMPLE);
        stim_valid_d  = busy_d;
        resp_sample_d = (state_d == S_SAMPLE);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            stim_q        <= '0;
            vec_count_q   <= '0;
            signature_q   <= '0;
            settle_cnt_q  <= '0;
            stim_valid_q  <= 1'b0;
            resp_sample_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            stim_q        <= stim_d;
            vec_count_q   <= vec_count_d;
            signature_q   <= signature_d;
            settle_cnt_q  <= settle_cnt_d;
            stim_valid_q  <= stim_valid_d;
            resp_sample_q <= resp_sample_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.stim        = stim_q;
    assign bus.vec_count   = vec_count_q;
    assign bus.signature   = signature_q;
    assign bus.stim_valid  = stim_valid_q;
    assign bus.resp_sample = resp_sample_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_stim_sweep_gen.sv
// ---------------------------------------------------------------------------
// tb_stim_sweep_gen
// Three generator instances:
//   A: IN_W=2, OUT_W=2, SETTLE=1, resp = stim        (loopback)
//   B: IN_W=5, OUT_W=6, SETTLE=0, resp = &stim       (and gate)
//   C: IN_W=4, OUT_W=4, SETTLE=3, resp = ~stim       (longer settle)
// Expected samples are queued when a sweep is issued; a negedge monitor pops
// and compares on every resp_sample pulse.
// ---------------------------------------------------------------------------
module tb_stim_sweep_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stim_sweep_gen_if #(.IN_W(2), .OUT_W(2), .SIG_W(16)) bus_a ();
    stim_sweep_gen_if #(.IN_W(5), .OUT_W(6), .SIG_W(16)) bus_b ();
    stim_sweep_gen_if #(.IN_W(4), .OUT_W(4), .SIG_W(16)) bus_c ();

    stim_sweep_gen #(.IN_W(2), .OUT_W(2), .SETTLE(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    stim_sweep_gen #(.IN_W(5), .OUT_W(6), .SETTLE(0)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    stim_sweep_gen #(.IN_W(4), .OUT_W(4), .SETTLE(3)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

    // DUT models driven from stim
    assign bus_a.resp = bus_a.stim;
    assign bus_b.resp = {5'b0, &bus_b.stim};
    assign bus_c.resp = ~bus_c.stim;

    // Uniform views of the three instances
    logic        start_v [3];
    logic [15:0] stim_v  [3];
    logic [16:0] vc_v    [3];
    logic [15:0] sig_v   [3];
    logic        sv_v    [3];
    logic        rs_v    [3];
    logic        busy_v  [3];
    logic        done_v  [3];

    assign bus_a.start = start_v[0];
    assign bus_b.start = start_v[1];
    assign bus_c.start = start_v[2];

    assign stim_v[0] = 16'(bus_a.stim);
    assign stim_v[1] = 16'(bus_b.stim);
    assign stim_v[2] = 16'(bus_c.stim);
    assign vc_v[0]   = 17'(bus_a.vec_count);
    assign vc_v[1]   = 17'(bus_b.vec_count);
    assign vc_v[2]   = 17'(bus_c.vec_count);
    assign sig_v[0]  = bus_a.signature;
    assign sig_v[1]  = bus_b.signature;
    assign sig_v[2]  = bus_c.signature;
    assign sv_v[0]   = bus_a.stim_valid;
    assign sv_v[1]   = bus_b.stim_valid;
    assign sv_v[2]   = bus_c.stim_valid;
    assign rs_v[0]   = bus_a.resp_sample;
    assign rs_v[1]   = bus_b.resp_sample;
    assign rs_v[2]   = bus_c.resp_sample;
    assign busy_v[0] = bus_a.busy;
    assign busy_v[1] = bus_b.busy;
    assign busy_v[2] = bus_c.busy;
    assign done_v[0] = bus_a.done;
    assign done_v[1] = bus_b.done;
    assign done_v[2] = bus_c.done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_cyc [3];
    int settle_of [3] = '{1, 0, 3};

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] idx;
        logic [15:0] v;
    } sb_t;

    sb_t qa[$];
    sb_t qb[$];
    sb_t qc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int v);
        sb_t e;
        e.idx = 16'(v);
        e.v   = 16'(v);
        case (s)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic flush(input int s);
        case (s)
            0:       qa.delete();
            1:       qb.delete();
            default: qc.delete();
        endcase
    endtask

    function automatic int qsize(input int s);
        case (s)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    // Monitor: pop one expected entry per resp_sample pulse
    task automatic mon(input int s);
        sb_t e;
        bit  got;
        got = 1'b0;
        e   = '0;
        case (s)
            0:       if (qa.size() > 0) begin e = qa.pop_front(); got = 1'b1; end
            1:       if (qb.size() > 0) begin e = qb.pop_front(); got = 1'b1; end
            default: if (qc.size() > 0) begin e = qc.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL extra_sample inst%0d actual stim=%0h required no sample", s, stim_v[s]);
        end else begin
            check($sformatf("sample_stim inst%0d", s), 32'(stim_v[s]), 32'(e.v));
            check($sformatf("sample_vec_count inst%0d", s), 32'(vc_v[s]), 32'(e.idx));
            if (e.idx != 16'd0)
                check($sformatf("sample_spacing inst%0d", s), 32'(cyc - last_cyc[s]),
                      32'(settle_of[s] + 2));
            last_cyc[s] = cyc;
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (rs_v[s] === 1'b1) mon(s);
        end
    end

    task automatic check_zero(input int s, input string tag);
        check($sformatf("%s stim inst%0d", tag, s),        32'(stim_v[s]), 0);
        check($sformatf("%s vec_count inst%0d", tag, s),   32'(vc_v[s]),   0);
        check($sformatf("%s signature inst%0d", tag, s),   32'(sig_v[s]),  0);
        check($sformatf("%s stim_valid inst%0d", tag, s),  32'(sv_v[s]),   0);
        check($sformatf("%s resp_sample inst%0d", tag, s), 32'(rs_v[s]),   0);
        check($sformatf("%s busy inst%0d", tag, s),        32'(busy_v[s]), 0);
        check($sformatf("%s done inst%0d", tag, s),        32'(done_v[s]), 0);
    endtask

    // Issue one sweep. glitch: cycle at which start is re-pulsed while busy
    // (-1 none). abort_at: cycle at which rst is pulsed (-1 none).
    task automatic run(input int s, input int nvec, input int exp_cyc,
                       input logic [15:0] exp_sig, input int glitch, input int abort_at);
        int n;
        bit fin;
        for (int v = 0; v < nvec; v++) push(s, v);
        @(posedge clk); #1 start_v[s] = 1'b1;
        @(posedge clk); #1 start_v[s] = 1'b0;
        check($sformatf("start done_cleared inst%0d", s), 32'(done_v[s]), 0);
        check($sformatf("start busy inst%0d", s),         32'(busy_v[s]), 1);
        check($sformatf("start vec_count inst%0d", s),    32'(vc_v[s]),   0);
        check($sformatf("start signature inst%0d", s),    32'(sig_v[s]),  0);
        check($sformatf("start stim inst%0d", s),         32'(stim_v[s]), 0);
        n   = 0;
        fin = 1'b0;
        while (!fin && n < 1000) begin
            @(posedge clk);
            n++;
            #1;
            if (n == glitch)     start_v[s] = 1'b1;
            if (n == glitch + 1) start_v[s] = 1'b0;
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                check_zero(s, "abort");
                flush(s);
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            if (done_v[s] === 1'b1) fin = 1'b1;
        end
        check($sformatf("done_latency inst%0d", s),  32'(n),          32'(exp_cyc));
        check($sformatf("end vec_count inst%0d", s), 32'(vc_v[s]),    32'(nvec));
        check($sformatf("end signature inst%0d", s), 32'(sig_v[s]),   32'(exp_sig));
        check($sformatf("end stim inst%0d", s),      32'(stim_v[s]),  32'(nvec - 1));
        check($sformatf("end busy inst%0d", s),      32'(busy_v[s]),  0);
        check($sformatf("end stim_valid inst%0d", s),32'(sv_v[s]),    0);
        check($sformatf("end pending inst%0d", s),   32'(qsize(s)),   0);
    endtask

    // Software MISR over the DUT models of instances B and C
    function automatic logic [15:0] model_sig(input int s, input int nvec);
        logic [15:0] sg;
        logic [15:0] vv;
        logic [15:0] r;
        sg = 16'h0;
        for (int v = 0; v < nvec; v++) begin
            vv = 16'(v);
            if (s == 1) r = {15'b0, &vv[4:0]};
            else        r = {12'b0, ~vv[3:0]};
            sg = {sg[14:0], 1'b0} ^ (sg[15] ? 16'h1021 : 16'h0000) ^ r;
        end
        return sg;
    endfunction

    initial begin
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start_v[s]  = 1'b0;
            last_cyc[s] = 0;
        end

        // Reset takes effect without a clock edge
        #2 rst = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) check_zero(s, "reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Loopback sweep: 0,1,2,3 -> signature 0x0003 after 12 cycles
        run(0, 4, 12, 16'h0003, -1, -1);
        // Restart from DONE reproduces the same result
        run(0, 4, 12, 16'h0003, -1, -1);
        // start re-pulsed during vector 2 is ignored
        run(0, 4, 12, 16'h0003, 6, -1);
        // rst during WAIT of vector 2, then a clean sweep from 0
        run(0, 4, 0, 16'h0000, -1, 7);
        check("post_abort stim", 32'(stim_v[0]), 0);
        check("post_abort done", 32'(done_v[0]), 0);
        run(0, 4, 12, 16'h0003, -1, -1);

        // And-gate truth table, SETTLE=0 (only vector 31 responds: 0x0001)
        run(1, 32, 64, model_sig(1, 32), -1, -1);
        // Inverter, SETTLE=3: signature grows past bit 15 and exercises POLY
        run(2, 16, 80, model_sig(2, 16), -1, -1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
